// File: rtl/mul_approx_pipe.sv
// Unsigned WIDTHxWIDTH multiplier, exact or column-truncated per operation, STAGES-deep valid/ready pipeline.
// Latency STAGES cycles; a stage advances when empty or when its successor advances, so a full pipe still streams.
module mul_approx_pipe #(
    parameter int WIDTH  = 8,
    parameter int TRUNC  = 4,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   o,
    output logic                 o_approx,
    output logic [15:0]          ops_cnt
);

    localparam int PW   = 2 * WIDTH;
    localparam int LAST = STAGES - 1;
    localparam int CSH  = (TRUNC > 0) ? (TRUNC - 1) : 0;
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] COMP = (TRUNC > 0) ? (ONE << CSH) : '0;

    logic [PW-1:0]     w_exact;
    logic [PW-1:0]     w_approx;
    logic [PW-1:0]     w_prod;
    logic [STAGES-1:0] w_adv;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_tag;
    logic [PW-1:0]     r_dat [STAGES];
    logic [15:0]       r_cnt;

    // Approximate product keeps only partial-product columns at or above TRUNC, plus a half-LSB bias.
    always_comb begin
        w_exact  = PW'(a) * PW'(b);
        w_approx = COMP;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (((i + j) >= TRUNC) && a[i] && b[j]) begin
                    w_approx = w_approx + (ONE << (i + j));
                end
            end
        end
        if ((a == '0) || (b == '0)) begin
            w_approx = '0;
        end
        w_prod = approx ? w_approx : w_exact;
    end

    // Stage s can move iff some stage at or after it is empty, or the consumer takes the head.
    always_comb begin
        w_adv = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_adv[s] = out_ready;
            for (int k = s; k < STAGES; k++) begin
                if (!r_vld[k]) begin
                    w_adv[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_tag <= '0;
            r_cnt <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_dat[s] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= in_valid;
                if (in_valid) begin
                    r_dat[0] <= w_prod;
                    r_tag[0] <= approx;
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                if (w_adv[s]) begin
                    r_vld[s] <= r_vld[s-1];
                    if (r_vld[s-1]) begin
                        r_dat[s] <= r_dat[s-1];
                        r_tag[s] <= r_tag[s-1];
                    end
                end
            end
            if (r_vld[LAST] && out_ready) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[LAST];
    assign o         = r_dat[LAST];
    assign o_approx  = r_tag[LAST];
    assign ops_cnt   = r_cnt;

endmodule

// File: tb/tb_mul_approx_pipe.sv
// Bench for mul_approx_pipe: directed vectors, backpressure, reset and counter-wrap sequences, random streams.
module tb_mul_approx_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        approx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] o;
    logic        o_approx;
    logic [15:0] ops_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [15:0] o2;
    logic        o_approx2;
    logic [15:0] ops_cnt2;

    always #5 clk = ~clk;

    mul_approx_pipe #(.WIDTH(8), .TRUNC(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx(approx), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .o_approx(o_approx), .ops_cnt(ops_cnt)
    );

    mul_approx_pipe #(.WIDTH(8), .TRUNC(0), .STAGES(2)) dut_t0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .approx(approx), .out_valid(out_valid2), .out_ready(out_ready),
        .o(o2), .o_approx(o_approx2), .ops_cnt(ops_cnt2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ap;
    } op_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ap;
        longint     exp_t4;
        longint     exp_t0;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    op_t         q[$];
    int          acc_cnt = 0;
    int          cyc = 0;
    int          last_xfer = -10;
    int          run = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Rows of the product with truncated low columns removed, then the half-LSB bias added.
    function automatic longint ref_mul(input logic [7:0] x, input logic [7:0] y, input logic ap, input int tr);
        longint p;
        p = longint'(x) * longint'(y);
        if (!ap) return p;
        if (x == 8'd0 || y == 8'd0) return 0;
        for (int i = 0; i < tr && i < 8; i++) begin
            if (x[i]) p -= (longint'(y) % (longint'(1) << (tr - i))) << i;
        end
        if (tr > 0) p += longint'(1) << (tr - 1);
        return p;
    endfunction

    always @(negedge clk) begin
        op_t e;
        cyc++;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_out: got o=%0d with no operation outstanding, expected none", o);
                end else begin
                    e = q.pop_front();
                    check("sb_o", o, ref_mul(e.a, e.b, e.ap, 4));
                    check("sb_tag", o_approx, e.ap);
                    check("sb_o_trunc0", o2, ref_mul(e.a, e.b, e.ap, 0));
                end
                exp_cnt++;
                run = (cyc == last_xfer + 1) ? run + 1 : 1;
                last_xfer = cyc;
            end
            if (in_valid && in_ready) begin
                q.push_back('{a: a, b: b, ap: approx});
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (q.size() == 0 && !out_valid) break;
            tick();
        end
        check(nm, q.size(), 0);
    endtask

    task automatic send_one(input string nm, input logic [7:0] aa, input logic [7:0] bb,
                            input logic ap, input longint e4, input longint e0);
        a = aa; b = bb; approx = ap; in_valid = 1'b1; out_ready = 1'b1;
        check({nm, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({nm, "_lat1_vld"}, out_valid, 0);
        tick();
        check({nm, "_lat2_vld"}, out_valid, 1);
        check({nm, "_o"}, o, e4);
        check({nm, "_tag"}, o_approx, ap);
        check({nm, "_o_trunc0"}, o2, e0);
        tick();
    endtask

    initial begin
        vec_t vt[6];
        int   acc0;
        int   stray;
        vt[0] = '{a: 8'd255, b: 8'd255, ap: 1'b0, exp_t4: 65025, exp_t0: 65025};
        vt[1] = '{a: 8'd255, b: 8'd255, ap: 1'b1, exp_t4: 64984, exp_t0: 65025};
        vt[2] = '{a: 8'd3,   b: 8'd3,   ap: 1'b1, exp_t4: 8,     exp_t0: 9};
        vt[3] = '{a: 8'd0,   b: 8'd200, ap: 1'b1, exp_t4: 0,     exp_t0: 0};
        vt[4] = '{a: 8'd0,   b: 8'd200, ap: 1'b0, exp_t4: 0,     exp_t0: 0};
        vt[5] = '{a: 8'd200, b: 8'd0,   ap: 1'b1, exp_t4: 0,     exp_t0: 0};

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; approx = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_ops_cnt", ops_cnt, 0);
        check("rst_o", o, 0);
        check("rst_o_approx", o_approx, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Back-to-back mixed-mode burst.
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            a = 8'($urandom); b = 8'($urandom); approx = n[0]; in_valid = 1'b1;
            tick();
        end
        drain("burst_drain");
        check("burst_ops_cnt", ops_cnt, 10);
        check("burst_consecutive", run, 10);

        for (int i = 0; i < 6; i++) begin
            send_one($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].ap, vt[i].exp_t4, vt[i].exp_t0);
        end

        // Stall: two accepts fill the pipe, then in_ready must drop and the head must hold.
        acc0 = acc_cnt;
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            a = 8'($urandom); b = 8'($urandom); approx = 1'($urandom); in_valid = 1'b1;
            tick();
            if (out_valid && q.size() > 0) begin
                check("stall_o", o, ref_mul(q[0].a, q[0].b, q[0].ap, 4));
                check("stall_tag", o_approx, q[0].ap);
            end
        end
        check("stall_accepts", acc_cnt - acc0, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("full_pass_in_ready", in_ready, 1);
        tick();
        drain("stall_drain");
        check("stall_total", acc_cnt - acc0, 3);

        // Reset with two operations in flight.
        a = 8'd17; b = 8'd29; approx = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a = 8'd99; b = 8'd7; approx = 1'b1;
        tick();
        in_valid = 1'b0;
        check("inflight_vld", out_valid, 1);
        #2 rst_n = 1'b0;
        q.delete();
        exp_cnt = 16'd0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ops_cnt", ops_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (out_valid) stray++;
        end
        check("midrst_no_stale", stray, 0);
        check("midrst_in_ready", in_ready, 1);

        // Counter wrap.
        out_ready = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            a = 8'($urandom); b = 8'($urandom); approx = 1'($urandom); in_valid = 1'b1;
            tick();
        end
        drain("wrap_drain");
        check("cnt_65535", ops_cnt, 65535);
        send_one("wrap_op", 8'd255, 8'd255, 1'b1, 64984, 65025);
        check("cnt_wrap0", ops_cnt, 0);

        // Random valid/ready traffic.
        for (int n = 0; n < 400; n++) begin
            a = 8'($urandom); b = 8'($urandom); approx = 1'($urandom);
            in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("rand_drain");
        check("rand_ops_cnt", ops_cnt, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_approx_pipe.md
MUL_APPROX_PIPE -- requirements
Module: mul_approx_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 4..16.
REQ-002 Parameter TRUNC, default 4: number of least-significant partial-product columns omitted in approximate mode; legal range 0..WIDTH.
REQ-003 Parameter STAGES, default 2: pipeline depth in registered stages; legal range 1..4.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 Port in_valid  in  1: a, b and approx are valid this cycle.
REQ-007 Port in_ready  out  1: the block accepts an operation this cycle.
REQ-008 Port a  in  WIDTH: unsigned multiplicand.
REQ-009 Port b  in  WIDTH: unsigned multiplier.
REQ-010 Port approx  in  1: per-operation mode; 0 = exact, 1 = truncated approximate.
REQ-011 Port out_valid  out  1: o and o_approx hold a result.
REQ-012 Port out_ready  in  1: the consumer takes the result this cycle.
REQ-013 Port o  out  2*WIDTH: product.
REQ-014 Port o_approx  out  1: mode tag of the operation now on o.
REQ-015 Port ops_cnt  out  16: count of completed output transfers; wraps modulo 2^16.

Function
REQ-016 The block SHALL accept an operation when in_valid && in_ready is high at a clock edge.
REQ-017 The block SHALL complete an output transfer when out_valid && out_ready is high at a clock edge.
REQ-018 With approx=0, o SHALL equal a*b exactly.
REQ-019 With approx=1, o SHALL equal the sum over all i,j with i+j >= TRUNC of (a[i]&b[j])<<(i+j), plus 2^(TRUNC-1) when TRUNC>0.
REQ-020 With approx=1, if a==0 or b==0, o SHALL be 0 (zero-forcing overrides the compensation term).
REQ-021 The approximate result SHALL never exceed 2^(2*WIDTH)-1; no saturation logic is required for legal parameters.
REQ-022 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
REQ-023 Throughput SHALL be one operation per cycle while out_ready stays high.
REQ-024 Each stage SHALL hold a valid bit; a stage SHALL advance when it is empty or the next stage advances.
REQ-025 The final stage advances on out_ready.
REQ-026 in_ready SHALL equal (stage-1 empty) OR (stage 1 advances) in the same cycle; no combinational path from in_valid to in_ready.
REQ-027 While out_valid=1 and out_ready=0, o, o_approx and out_valid SHALL hold stable; no operation is lost or duplicated.
REQ-028 When the pipeline is full and stalled, in_ready SHALL be 0.
REQ-029 Operations SHALL leave in acceptance order.
REQ-030 Each output SHALL carry the approx value captured with its own operands, so mixed-mode streams are allowed.
REQ-031 A result SHALL be allowed to leave and a new operation to be accepted in the same cycle while the pipeline is full.
REQ-032 ops_cnt SHALL increment by 1 on each output transfer and wrap from 65535 to 0.

Reset
REQ-033 On rst_n low, all stage valid bits, out_valid and ops_cnt SHALL clear to 0 immediately, regardless of clk; o=0, o_approx=0.
REQ-034 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-035 Reset mid-operation SHALL discard all in-flight operations; none appear after release.

Verification (WIDTH=8, TRUNC=4, STAGES=2 unless stated)
REQ-036 a=255, b=255: approx=0 -> o=65025; approx=1 -> o=64984, o_approx=1, each 2 cycles after acceptance.
REQ-037 a=3, b=3, approx=1 -> o=8; a=0, b=200, approx=1 -> o=0; a=0, b=200, approx=0 -> o=0.
REQ-038 Back-to-back stream of 10 mixed-mode operations with out_ready=1 -> 10 results on consecutive cycles in order with correct tags; ops_cnt=10.
REQ-039 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts; o stays stable; release -> all results in order, none dropped.
REQ-040 Assert rst_n=0 with 2 operations in flight -> out_valid=0 and ops_cnt=0 immediately; no stale results after release.
REQ-041 Preload ops_cnt to 65535 via transfers, then 1 more transfer -> ops_cnt=0; repeat REQ-036 with TRUNC=0 -> approximate equals exact.
